// File: rtl/calc_seq.sv
// calc_seq: sequencer for the BCD calculator (DEC->BIN A/B, ALD, BIN->DEC).
// Option macro CALC_SEQ_OVF_SAT_EN: on overflow skip B2D, saturate result.
module calc_seq #(
  parameter int TO_CYC = 1024,
  parameter int TO_W   = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic [15:0] Adec,
  input  logic [15:0] Bdec,
  output logic [15:0] cvt_di,
  output logic        cvt_st,
  input  logic        cvt_rdy,
  input  logic [15:0] cvt_bin,
  output logic [15:0] opA,
  output logic [15:0] opB,
  output logic        alu_st,
  input  logic        alu_rdy,
  input  logic [31:0] alu_q,
  output logic [26:0] b2d_bin,
  output logic        b2d_st,
  input  logic        b2d_rdy,
  input  logic [31:0] b2d_dec,
  output logic [31:0] result,
  output logic        busy,
  output logic        valid,
  output logic        ovf,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, CA, CB, ALU, B2D} state_t;

  localparam logic [31:0]     MAX_DEC = 32'd99_999_999;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);

  state_t      state_q, state_d;
  logic        go_q;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [15:0] cvt_di_q, cvt_di_d;
  logic        cvt_st_q, cvt_st_d;
  logic [15:0] opA_q, opA_d, opB_q, opB_d;
  logic        alu_st_q, alu_st_d;
  logic [26:0] b2d_bin_q, b2d_bin_d;
  logic        b2d_st_q, b2d_st_d;
  logic [31:0] result_q, result_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  logic        ovf_q, ovf_d;
  logic        err_q, err_d;
  logic        go_rise, rdy, rdy_ok, tmo;

  assign go_rise = go & ~go_q;
  // rdy seen while our own start pulse is still out is a stale response
  assign rdy_ok  = rdy & ~(cvt_st_q | alu_st_q | b2d_st_q);
  assign tmo     = (cnt_q == TO_LAST);

  // select the done pulse of the stage currently waiting
  always_comb begin
    rdy = 1'b0;
    unique case (state_q)
      CA, CB:  rdy = cvt_rdy;
      ALU:     rdy = alu_rdy;
      B2D:     rdy = b2d_rdy;
      default: rdy = 1'b0;
    endcase
  end

  // next state, stage hand-offs and timeout handling
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = (state_q == IDLE) ? cnt_q : cnt_q + 1'b1;
    cvt_di_d  = cvt_di_q;
    cvt_st_d  = 1'b0;
    opA_d     = opA_q;
    opB_d     = opB_q;
    alu_st_d  = 1'b0;
    b2d_bin_d = b2d_bin_q;
    b2d_st_d  = 1'b0;
    result_d  = result_q;
    busy_d    = busy_q;
    valid_d   = valid_q;
    ovf_d     = ovf_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        if (go_rise) begin
          state_d  = CA;
          a_d      = Adec;
          b_d      = Bdec;
          cvt_di_d = Adec;
          cvt_st_d = 1'b1;
          cnt_d    = '0;
          busy_d   = 1'b1;
          valid_d  = 1'b0;
          ovf_d    = 1'b0;
          err_d    = 1'b0;
        end
      end
      CA: begin
        if (rdy_ok) begin
          opA_d    = cvt_bin;
          cvt_di_d = b_q;
          cvt_st_d = 1'b1;
          cnt_d    = '0;
          state_d  = CB;
        end
      end
      CB: begin
        if (rdy_ok) begin
          opB_d    = cvt_bin;
          alu_st_d = 1'b1;
          cnt_d    = '0;
          state_d  = ALU;
        end
      end
      ALU: begin
        if (rdy_ok) begin
          b2d_bin_d = alu_q[26:0];
          ovf_d     = (alu_q > MAX_DEC);
          cnt_d     = '0;
`ifdef CALC_SEQ_OVF_SAT_EN
          if (alu_q > MAX_DEC) begin
            result_d = 32'h9999_9999;
            valid_d  = 1'b1;
            busy_d   = 1'b0;
            state_d  = IDLE;
          end else begin
            b2d_st_d = 1'b1;
            state_d  = B2D;
          end
`else
          b2d_st_d = 1'b1;
          state_d  = B2D;
`endif
        end
      end
      B2D: begin
        if (rdy_ok) begin
          result_d = b2d_dec;
          valid_d  = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && !rdy_ok && tmo) begin
      err_d   = 1'b1;
      busy_d  = 1'b0;
      valid_d = 1'b0;
      state_d = IDLE;
    end
  end

  // state and output registers; go_q resets high so a held go cannot start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      go_q      <= 1'b1;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      cvt_di_q  <= '0;
      cvt_st_q  <= 1'b0;
      opA_q     <= '0;
      opB_q     <= '0;
      alu_st_q  <= 1'b0;
      b2d_bin_q <= '0;
      b2d_st_q  <= 1'b0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      go_q      <= go;
      a_q       <= a_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      cvt_di_q  <= cvt_di_d;
      cvt_st_q  <= cvt_st_d;
      opA_q     <= opA_d;
      opB_q     <= opB_d;
      alu_st_q  <= alu_st_d;
      b2d_bin_q <= b2d_bin_d;
      b2d_st_q  <= b2d_st_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
    end
  end

  assign cvt_di  = cvt_di_q;
  assign cvt_st  = cvt_st_q;
  assign opA     = opA_q;
  assign opB     = opB_q;
  assign alu_st  = alu_st_q;
  assign b2d_bin = b2d_bin_q;
  assign b2d_st  = b2d_st_q;
  assign result  = result_q;
  assign busy    = busy_q;
  assign valid   = valid_q;
  assign ovf     = ovf_q;
  assign err     = err_q;

endmodule

// File: tb/tb_calc_seq.sv
// tb_calc_seq: randomized bench for calc_seq with a schedule-based model.
// Responders are bench processes with per-stage programmable latency.
`timescale 1ns/1ps
module tb_calc_seq;

  localparam int TO = 16;
`ifdef CALC_SEQ_OVF_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0;
  logic [15:0] Adec = '0, Bdec = '0;
  logic [15:0] cvt_di, cvt_bin = '0;
  logic        cvt_st, cvt_rdy = 1'b0;
  logic [15:0] opA, opB;
  logic        alu_st, alu_rdy = 1'b0;
  logic [31:0] alu_q = '0;
  logic [26:0] b2d_bin;
  logic        b2d_st, b2d_rdy = 1'b0;
  logic [31:0] b2d_dec = '0;
  logic [31:0] result;
  logic        busy, valid, ovf, err;

  calc_seq #(.TO_CYC(TO), .TO_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .Adec(Adec), .Bdec(Bdec),
    .cvt_di(cvt_di), .cvt_st(cvt_st), .cvt_rdy(cvt_rdy), .cvt_bin(cvt_bin),
    .opA(opA), .opB(opB), .alu_st(alu_st), .alu_rdy(alu_rdy),
    .alu_q(alu_q), .b2d_bin(b2d_bin), .b2d_st(b2d_st),
    .b2d_rdy(b2d_rdy), .b2d_dec(b2d_dec), .result(result),
    .busy(busy), .valid(valid), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] bcd2bin(input logic [15:0] d);
    return 16'(d[15:12] * 1000 + d[11:8] * 100 + d[7:4] * 10 + d[3:0]);
  endfunction

  function automatic logic [31:0] bin2bcd(input logic [31:0] v);
    logic [31:0] r = '0;
    logic [31:0] t = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  typedef struct packed {
    logic [15:0] cvt_di;
    logic        cvt_st;
    logic [15:0] opA;
    logic [15:0] opB;
    logic        alu_st;
    logic [26:0] b2d_bin;
    logic        b2d_st;
    logic [31:0] result;
    logic        busy;
    logic        valid;
    logic        ovf;
    logic        err;
  } exp_t;

  // model: one transaction described by its stage schedule
  exp_t        prev = '0;
  bit          have_txn = 1'b0;
  int          t0 = 0;
  logic [15:0] mA, mB, binA, binB;
  logic [31:0] m_alu, resv;
  int          s[4], c[4];
  int          nst, ncomp, end_c;
  bit          success;
  int          dly[4];
  bit          spur = 1'b0;
  bit          chk_en = 1'b1;

  task automatic plan();
    int t = 0;
    bit fin = 1'b0;
    nst = 0; ncomp = 0; success = 1'b0; end_c = 0;
    for (int k = 0; k < 4; k++) begin
      if (!fin) begin
        s[k] = t;
        nst = k + 1;
        if (dly[k] == 0 || dly[k] > TO - 1) begin
          end_c = t + TO;
          fin = 1'b1;
        end else begin
          c[k] = t + dly[k] + 1;
          ncomp = k + 1;
          t = c[k];
          if (k == 2 && SAT && m_alu > 32'd99_999_999) begin
            end_c = t; success = 1'b1; resv = 32'h9999_9999; fin = 1'b1;
          end else if (k == 3) begin
            end_c = t; success = 1'b1;
            resv = bin2bcd({5'd0, m_alu[26:0]});
            fin = 1'b1;
          end
        end
      end
    end
  endtask

  function automatic exp_t exp_at(input int rel);
    exp_t x = prev;
    if (!have_txn || rel < 0) return prev;
    x.cvt_st  = (rel == s[0]) || (nst > 1 && rel == s[1]);
    x.alu_st  = (nst > 2 && rel == s[2]);
    x.b2d_st  = (nst > 3 && rel == s[3]);
    x.cvt_di  = (nst > 1 && rel >= s[1]) ? mB : mA;
    if (ncomp > 0 && rel >= c[0]) x.opA = binA;
    if (ncomp > 1 && rel >= c[1]) x.opB = binB;
    x.ovf = 1'b0;
    if (ncomp > 2 && rel >= c[2]) begin
      x.b2d_bin = m_alu[26:0];
      x.ovf     = (m_alu > 32'd99_999_999);
    end
    x.busy  = (rel < end_c);
    x.valid = (rel >= end_c) && success;
    x.err   = (rel >= end_c) && !success;
    if (x.valid) x.result = resv;
    return x;
  endfunction

  // responders: programmable latency, optional stale rdy in the start cycle
  int cc = 0, ac = 0, bc = 0;
  int cvt_total = 0, b2d_total = 0;
  int cvt_base = 0;
  logic [15:0] cv;
  logic [31:0] av, bv;
  bit alu_force = 1'b0;
  logic [31:0] alu_fv = '0;
  always @(negedge clk) begin
    cvt_rdy = 1'b0; alu_rdy = 1'b0; b2d_rdy = 1'b0;
    if (!rst_n) begin
      cc = 0; ac = 0; bc = 0;
    end else begin
      if (cc > 0) begin
        cc--;
        if (cc == 0) begin cvt_rdy = 1'b1; cvt_bin = cv; end
      end
      if (ac > 0) begin
        ac--;
        if (ac == 0) begin alu_rdy = 1'b1; alu_q = av; end
      end
      if (bc > 0) begin
        bc--;
        if (bc == 0) begin b2d_rdy = 1'b1; b2d_dec = bv; end
      end
      if (cvt_st) begin
        cc = dly[(cvt_total - cvt_base) > 0 ? 1 : 0];
        cv = bcd2bin(cvt_di);
        if (spur && cvt_total == cvt_base) begin
          cvt_rdy = 1'b1; cvt_bin = 16'hFFFF;
        end
        cvt_total++;
      end
      if (alu_st) begin
        ac = dly[2];
        av = alu_force ? alu_fv : {16'd0, opA} + {16'd0, opB};
      end
      if (b2d_st) begin
        bc = dly[3];
        bv = bin2bcd({5'd0, b2d_bin});
        b2d_total++;
      end
    end
  end

  // compare every output against the model each cycle
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      exp_t x;
      x = exp_at(cyc - t0);
      chk("cvt_di", {16'd0, cvt_di}, {16'd0, x.cvt_di});
      chk("cvt_st", {31'd0, cvt_st}, {31'd0, x.cvt_st});
      chk("opA", {16'd0, opA}, {16'd0, x.opA});
      chk("opB", {16'd0, opB}, {16'd0, x.opB});
      chk("alu_st", {31'd0, alu_st}, {31'd0, x.alu_st});
      chk("b2d_bin", {5'd0, b2d_bin}, {5'd0, x.b2d_bin});
      chk("b2d_st", {31'd0, b2d_st}, {31'd0, x.b2d_st});
      chk("result", result, x.result);
      chk("busy", {31'd0, busy}, {31'd0, x.busy});
      chk("valid", {31'd0, valid}, {31'd0, x.valid});
      chk("ovf", {31'd0, ovf}, {31'd0, x.ovf});
      chk("err", {31'd0, err}, {31'd0, x.err});
    end
  end

  task automatic wait_done();
    int n = 0;
    while (have_txn && (cyc - t0) < end_c && n < 200) begin
      @(negedge clk); n++;
    end
    if (n >= 200) chk("done_bound", 32'(n), 32'd0);
  endtask

  task automatic wait_rel(input int r);
    int n = 0;
    while ((cyc - t0) < r && n < 200) begin
      @(negedge clk); n++;
    end
  endtask

  task automatic start(input logic [15:0] a, input logic [15:0] b,
                       input int d0, input int d1, input int d2,
                       input int d3, input bit sp, input bit frc,
                       input logic [31:0] fv);
    wait_done();
    go = 1'b0;
    @(negedge clk);
    prev = exp_at(cyc - t0);
    Adec = a; Bdec = b;
    dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
    spur = sp; alu_force = frc; alu_fv = fv;
    cvt_base = cvt_total;
    mA = a; mB = b; binA = bcd2bin(a); binB = bcd2bin(b);
    m_alu = frc ? fv : {16'd0, binA} + {16'd0, binB};
    plan();
    have_txn = 1'b1;
    t0 = cyc + 1;
    go = 1'b1;
  endtask

  function automatic logic [15:0] rbcd();
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  function automatic int rdly();
    int p = $urandom_range(0, 15);
    if (p == 0) return 0;
    if (p == 1) return TO;
    if (p == 2) return TO - 1;
    return $urandom_range(1, 5);
  endfunction

  initial begin
    int b2d0;
    go = 1'b1;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_result", result, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("held_go_idle", {31'd0, busy}, 32'd0);

    // 1234 + 56 with zero-wait responders
    start(16'h1234, 16'h0056, 1, 1, 1, 1, 1'b0, 1'b0, 32'd0);
    chk("model_end", 32'(end_c), 32'd8);
    wait_rel(7);
    chk("t7_valid", {31'd0, valid}, 32'd0);
    chk("t7_busy", {31'd0, busy}, 32'd1);
    wait_rel(8);
    chk("t8_valid", {31'd0, valid}, 32'd1);
    chk("t8_busy", {31'd0, busy}, 32'd0);
    chk("t8_result", result, 32'h0000_1290);
    chk("t8_opA", {16'd0, opA}, 32'd1234);
    chk("t8_opB", {16'd0, opB}, 32'd56);

    // converter stalls in CB: timeout 16 cycles after cvt_st
    start(16'h0001, 16'h0002, 1, 0, 1, 1, 1'b0, 1'b0, 32'd0);
    wait_rel(17);
    chk("to17_err", {31'd0, err}, 32'd0);
    wait_rel(18);
    chk("to18_err", {31'd0, err}, 32'd1);
    chk("to18_busy", {31'd0, busy}, 32'd0);
    chk("to18_valid", {31'd0, valid}, 32'd0);
    chk("to18_result", result, 32'h0000_1290);

    // overflow magnitude
    b2d0 = b2d_total;
    start(16'h0000, 16'h0000, 1, 1, 1, 1, 1'b0, 1'b1, 32'd100_000_000);
    wait_done();
    chk("ovf_flag", {31'd0, ovf}, 32'd1);
    chk("ovf_valid", {31'd0, valid}, 32'd1);
    chk("ovf_b2d_n", 32'(b2d_total - b2d0), SAT ? 32'd0 : 32'd1);
    chk("ovf_result", result, SAT ? 32'h9999_9999 : 32'h0000_0000);
    chk("ovf_end", 32'(end_c), SAT ? 32'd6 : 32'd8);

    // second go edge at cycle 3 with changed operands is ignored
    start(16'h0007, 16'h0003, 1, 1, 1, 1, 1'b0, 1'b0, 32'd0);
    wait_rel(1);
    go = 1'b0;
    wait_rel(2);
    go = 1'b1; Adec = 16'h9999; Bdec = 16'h9999;
    wait_done();
    chk("rego_result", result, 32'h0000_0010);

    // stale rdy during the start cycle is ignored
    start(16'h0100, 16'h0200, 3, 1, 1, 1, 1'b1, 1'b0, 32'd0);
    wait_done();
    chk("spur_opA", {16'd0, opA}, 32'd100);
    chk("spur_result", result, 32'h0000_0300);

    // reset mid-ALU, go held high across release
    start(16'h0011, 16'h0022, 1, 1, 5, 1, 1'b0, 1'b0, 32'd0);
    wait_rel(6);
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_opA", {16'd0, opA}, 32'd0);
    chk("mrst_alu_st", {31'd0, alu_st}, 32'd0);
    chk("mrst_b2d_bin", {5'd0, b2d_bin}, 32'd0);
    chk("mrst_result", result, 32'd0);
    have_txn = 1'b0;
    prev = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("mrst_idle", {31'd0, busy}, 32'd0);

    // randomized sequences
    for (int n = 0; n < 40; n++) begin
      bit frc = ($urandom_range(0, 3) == 0);
      start(rbcd(), rbcd(), rdly(), rdly(), rdly(), rdly(),
            1'($urandom_range(0, 1)), frc,
            32'($urandom_range(90_000_000, 134_217_727)));
      if ($urandom_range(0, 2) == 0) begin
        wait_rel(1);
        go = 1'b0;
        wait_rel(2);
        go = 1'b1; Adec = rbcd(); Bdec = rbcd();
      end
    end
    wait_done();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
